dll_code_slewer: RTL
====================

DLL_CODE_SLEWER -- requirements
Module: dll_code_slewer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4: clk_ext cycles per slew step (legal range 1..255).
REQ-002 The block SHALL have parameter SETTLE_CYC, default 8: number of ticks the code is held at target before completion is reported (legal range 1..255).
REQ-003 clk_ext  input  1  The single clock; all state updates on its rising edge.
REQ-004 rst  input  1  Synchronous, active-high reset.
REQ-005 code_in  input  10  Target delay code from the SAR: [9:6] coarse, [5:0] fine.
REQ-006 code_vld  input  1  One-cycle strobe; code_in is valid in the same cycle.
REQ-007 hold  input  1  When high, stepping and settle counting freeze and the tick counter stops.
REQ-008 T  output  16  Coarse delay-line select, thermometer-coded from applied[9:6].
REQ-009 Tb  output  16  Bitwise complement of T.
REQ-010 fine  output  6  Applied fine code, equal to applied[5:0].
REQ-011 code_out  output  10  Applied code register.
REQ-012 busy  output  1  High in SLEW and SETTLE.
REQ-013 done  output  1  One-cycle pulse on the SETTLE-to-IDLE transition.

Function
REQ-014 The block SHALL keep a 10-bit target register, a 10-bit applied register, and an 8-bit tick counter.
REQ-015 The tick counter SHALL count 0..TICK_DIV-1 while hold=0 and state is not IDLE; tick is asserted in the cycle the counter equals TICK_DIV-1.
REQ-016 On code_vld, target SHALL load code_in at the next edge, and the tick counter SHALL clear to 0.
REQ-017 States SHALL be IDLE, SLEW and SETTLE.
REQ-018 IDLE + code_vld SHALL go to SLEW if code_in != applied; otherwise it SHALL go to SETTLE.
REQ-019 In SLEW, on tick with hold=0: applied SHALL be incremented by 1 if applied < target, or decremented by 1 if applied > target (unsigned 10-bit compare).
REQ-020 Steps SHALL never exceed 1 LSB per tick; a fine carry or borrow into coarse SHALL occur naturally through 10-bit arithmetic.
REQ-021 SLEW SHALL go to SETTLE in the cycle after applied becomes equal to target, and the settle count SHALL clear.
REQ-022 In SETTLE, the settle count SHALL increment on each tick; on reaching SETTLE_CYC, the block SHALL go to IDLE and pulse done for 1 cycle.
REQ-023 code_vld in SLEW or SETTLE SHALL retarget: the new target loads, the settle count clears, and state goes to SLEW (or SETTLE if the new target equals applied).
REQ-024 If code_vld and tick coincide, the step in that cycle SHALL use the old target; the new target takes effect from the next tick.
REQ-025 applied SHALL saturate at 0 and 1023; no wrap-around is allowed.
REQ-026 T[i] SHALL equal 1 exactly when i < applied[9:6]: coarse 0 gives 16'h0000, coarse 15 gives 16'h7FFF.
REQ-027 T, Tb and fine SHALL be registered and SHALL change in the same cycle as code_out.
REQ-028 hold=1 SHALL freeze all registers except target; code_vld is still accepted while hold=1.
REQ-029 done SHALL NOT assert while busy would remain high in the next cycle.

Reset
REQ-030 When rst=1 at an edge: state=IDLE, target=applied=code_out=10'h200, T=16'h00FF, Tb=16'hFF00, fine=0, busy=0, done=0, and tick and settle counters=0.
REQ-031 rst SHALL take priority over code_vld and hold; reset mid-SLEW SHALL abandon the slew with no done pulse.

Verification
REQ-032 Reset, then code_vld with code_in=10'h203, TICK_DIV=4 -> code_out steps 201,202,203 at 4-cycle intervals; done pulses 8 ticks later; busy is low the next cycle.
REQ-033 code_in=10'h1C0 from 10'h200 -> the coarse boundary is crossed at 1FF; T changes 16'h00FF -> 16'h007F in the same cycle; Tb is always equal to ~T.
REQ-034 Retarget mid-slew (target 210, at 205 send 200) -> direction reverses, no step skipped, exactly one done pulse at the end.
REQ-035 hold=1 for 20 cycles mid-slew -> code_out frozen; stepping resumes with an unchanged tick phase after hold drops.
REQ-036 code_vld with code_in equal to applied -> SETTLE directly, done after SETTLE_CYC ticks, no code change.
REQ-037 Assert rst in SETTLE -> outputs return to the reset values next cycle; no done pulse.

Source files
------------

// File: rtl/dll_code_slewer.sv
// dll_code_slewer: moves the applied DLL delay code toward a SAR target one LSB
// per tick, then holds it for a settle window before reporting completion.
// Coarse bits drive a thermometer-coded line select; fine bits pass through.
module dll_code_slewer #(
    parameter int TICK_DIV   = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic        clk_ext,
    input  logic        rst,
    input  logic [9:0]  code_in,
    input  logic        code_vld,
    input  logic        hold,
    output logic [15:0] T,
    output logic [15:0] Tb,
    output logic [5:0]  fine,
    output logic [9:0]  code_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SLEW, SETTLE} state_t;

    localparam logic [7:0]  TICK_LAST   = 8'(TICK_DIV - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [9:0]  CODE_RST    = 10'h200;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  target;
    logic [9:0]  applied;
    logic [9:0]  applied_nxt;
    logic [7:0]  tick_cnt;
    logic [7:0]  settle_cnt;
    logic        tick;
    logic        step_en;
    logic        settle_tick;
    logic        finish;

    // One LSB toward the target, never wrapping past either end of the range.
    function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
        logic [9:0] r;
        r = cur;
        if ((cur < tgt) && (cur != 10'h3FF))
            r = cur + 10'd1;
        else if ((cur > tgt) && (cur != 10'h000))
            r = cur - 10'd1;
        return r;
    endfunction

    // Bit i set exactly when i is below the coarse code.
    function automatic logic [15:0] therm(input logic [3:0] c);
        logic [15:0] t;
        for (int i = 0; i < 16; i++)
            t[i] = (4'(i) < c);
        return t;
    endfunction

    assign tick        = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign step_en     = (state == SLEW) && tick && !hold;
    assign settle_tick = (state == SETTLE) && tick && !hold;
    // A retarget in the final settle tick cancels completion.
    assign finish      = settle_tick && (settle_cnt == SETTLE_LAST) && !code_vld;

    // A coincident retarget does not affect this cycle's step: old target is used.
    assign applied_nxt = step_en ? step_toward(applied, target) : applied;
    assign code_out    = applied;

    // State register.
    always_ff @(posedge clk_ext) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; a new code is accepted even while hold is high.
    always_comb begin
        state_nxt = state;
        if (code_vld) begin
            state_nxt = (code_in != applied) ? SLEW : SETTLE;
        end else if (!hold) begin
            case (state)
                SLEW:    if (applied == target) state_nxt = SETTLE;
                SETTLE:  if (finish)            state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        busy = (state != IDLE);
    end

    // Target capture, applied code and its registered line-select views.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            target  <= CODE_RST;
            applied <= CODE_RST;
            T       <= therm(CODE_RST[9:6]);
            Tb      <= ~therm(CODE_RST[9:6]);
            fine    <= CODE_RST[5:0];
            done    <= 1'b0;
        end else begin
            if (code_vld)
                target <= code_in;
            applied <= applied_nxt;
            T       <= therm(applied_nxt[9:6]);
            Tb      <= ~therm(applied_nxt[9:6]);
            fine    <= applied_nxt[5:0];
            done    <= finish;
        end
    end

    // Tick divider: restarts on a new code, freezes under hold, idles at 0.
    always_ff @(posedge clk_ext) begin
        if (rst)
            tick_cnt <= 8'd0;
        else if (code_vld)
            tick_cnt <= 8'd0;
        else if ((state != IDLE) && !hold)
            tick_cnt <= tick ? 8'd0 : tick_cnt + 8'd1;
    end

    // Settle counter: cleared on retarget or SETTLE entry, advanced per tick.
    always_ff @(posedge clk_ext) begin
        if (rst)
            settle_cnt <= 8'd0;
        else if (code_vld)
            settle_cnt <= 8'd0;
        else if ((state == SLEW) && (state_nxt == SETTLE))
            settle_cnt <= 8'd0;
        else if (settle_tick)
            settle_cnt <= finish ? 8'd0 : settle_cnt + 8'd1;
    end

endmodule
